// File: rtl/ste_shift_tx.sv
// ste_shift_tx: parallel-to-serial transmitter for the shift register receiver.
// Words enter through a valid/ready FIFO and are sent MSB first on a
// dout/shift_en pair, with a programmable idle gap after every word.
module ste_shift_tx #(
    parameter int SHIFT_W    = 24,
    parameter int FIFO_DEPTH = 4,
    parameter int GAP_W      = 4
) (
    input  logic                               clk,
    input  logic                               reset_i,
    input  logic [SHIFT_W-1:0]                 data_i,
    input  logic                               valid_i,
    output logic                               ready_o,
    input  logic [GAP_W-1:0]                   gap_i,
    input  logic                               clr_i,
    output logic                               dout_o,
    output logic                               shift_en_o,
    output logic                               shift_clr_o,
    output logic                               word_done_o,
    output logic                               busy_o,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    level_o
);

    localparam int BIT_W = (SHIFT_W > 2) ? $clog2(SHIFT_W) : 1;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_GAP   = 2'd2;

    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(SHIFT_W - 1);
    localparam logic [BIT_W-1:0] BIT_ONE  = BIT_W'(1'b1);
    localparam logic [BIT_W-1:0] BIT_ZERO = BIT_W'(1'b0);
    localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1'b1);
    localparam logic [GAP_W-1:0] GAP_ZERO = GAP_W'(1'b0);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1'b1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(1'b0);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

    // FIFO storage and pointers
    logic [SHIFT_W-1:0] mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_r;
    logic [PTR_W-1:0]   rd_ptr_r;
    logic [CNT_W-1:0]   count_r;

    // Serializer state
    logic [1:0]         state_r;
    logic [1:0]         state_nxt_s;
    logic [SHIFT_W-1:0] shreg_r;
    logic [BIT_W-1:0]   bit_cnt_r;
    logic [GAP_W-1:0]   gap_lat_r;
    logic [GAP_W-1:0]   gap_cnt_r;
    logic               last_bit_r;

    // Registered outputs
    logic               dout_r;
    logic               shift_en_r;
    logic               shift_clr_r;
    logic               word_done_r;

    logic               full_s;
    logic               empty_s;
    logic               ready_s;
    logic               push_s;
    logic               pop_raw_s;
    logic               pop_s;
    logic               kill_s;

    assign full_s  = (count_r == CNT_FULL);
    assign empty_s = (count_r == CNT_ZERO);
    assign kill_s  = reset_i | clr_i;
    // A pop in the same cycle never frees a slot early: no pass-through.
    assign ready_s = ~full_s & ~clr_i & ~reset_i;
    assign push_s  = valid_i & ready_s;
    assign pop_s   = pop_raw_s & ~kill_s;

    // Next-state decode and pop request for the serializer FSM
    always_comb begin
        state_nxt_s = state_r;
        pop_raw_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (!empty_s) begin
                    pop_raw_s   = 1'b1;
                    state_nxt_s = ST_SHIFT;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (bit_cnt_r != BIT_ZERO) begin
                    state_nxt_s = ST_SHIFT;
                end else if (gap_lat_r != GAP_ZERO) begin
                    state_nxt_s = ST_GAP;
                end else if (!empty_s) begin
                    // Zero gap: reload in the last-bit cycle so frames abut.
                    pop_raw_s   = 1'b1;
                    state_nxt_s = ST_SHIFT;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_GAP: begin
                if (gap_cnt_r != GAP_ONE) begin
                    state_nxt_s = ST_GAP;
                end else if (!empty_s) begin
                    pop_raw_s   = 1'b1;
                    state_nxt_s = ST_SHIFT;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                pop_raw_s   = 1'b0;
            end
        endcase
    end

    // FIFO data array write; contents are qualified by count, so no reset
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= data_i;
        end
    end

    // FIFO pointers and occupancy; flush empties everything
    always_ff @(posedge clk) begin
        if (kill_s) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= CNT_ZERO;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // Serializer datapath: load on pop, shift while in SHIFT, count the gap
    always_ff @(posedge clk) begin
        if (kill_s) begin
            state_r   <= ST_IDLE;
            shreg_r   <= '0;
            bit_cnt_r <= BIT_ZERO;
            gap_lat_r <= GAP_ZERO;
            gap_cnt_r <= GAP_ZERO;
        end else begin
            state_r <= state_nxt_s;
            if (pop_s) begin
                shreg_r   <= mem_r[rd_ptr_r];
                bit_cnt_r <= BIT_LAST;
                gap_lat_r <= gap_i;
            end else if (state_r == ST_SHIFT) begin
                shreg_r   <= {shreg_r[SHIFT_W-2:0], 1'b0};
                bit_cnt_r <= bit_cnt_r - BIT_ONE;
            end
            if ((state_r == ST_SHIFT) && (bit_cnt_r == BIT_ZERO)) begin
                gap_cnt_r <= gap_lat_r;
            end else if (state_r == ST_GAP) begin
                gap_cnt_r <= gap_cnt_r - GAP_ONE;
            end
        end
    end

    // Output registers; word_done trails the last bit by one cycle
    always_ff @(posedge clk) begin
        if (reset_i) begin
            dout_r      <= 1'b0;
            shift_en_r  <= 1'b0;
            shift_clr_r <= 1'b0;
            word_done_r <= 1'b0;
            last_bit_r  <= 1'b0;
        end else if (clr_i) begin
            dout_r      <= 1'b0;
            shift_en_r  <= 1'b0;
            shift_clr_r <= 1'b1;
            word_done_r <= 1'b0;
            last_bit_r  <= 1'b0;
        end else begin
            dout_r      <= (state_r == ST_SHIFT) & shreg_r[SHIFT_W-1];
            shift_en_r  <= (state_r == ST_SHIFT);
            shift_clr_r <= 1'b0;
            last_bit_r  <= (state_r == ST_SHIFT) && (bit_cnt_r == BIT_ZERO);
            word_done_r <= last_bit_r;
        end
    end

    assign ready_o     = ready_s;
    assign level_o     = count_r;
    assign busy_o      = (state_r != ST_IDLE);
    assign dout_o      = dout_r;
    assign shift_en_o  = shift_en_r;
    assign shift_clr_o = shift_clr_r;
    assign word_done_o = word_done_r;

endmodule

// File: tb/tb_ste_shift_tx.sv
// Directed bench for ste_shift_tx: a per-cycle driver feeds queued words,
// logs the serial outputs, and each scenario task checks the log against
// hand-computed cycle positions and word values.
module tb_ste_shift_tx;

    logic        clk = 1'b0;
    logic        reset_i = 1'b1;
    logic [23:0] data_i = 24'h0;
    logic        valid_i = 1'b0;
    logic        ready_o;
    logic [3:0]  gap_i = 4'd0;
    logic        clr_i = 1'b0;
    logic        dout_o, shift_en_o, shift_clr_o, word_done_o, busy_o;
    logic [2:0]  level_o;

    ste_shift_tx #(.SHIFT_W(24), .FIFO_DEPTH(4), .GAP_W(4)) dut (
        .clk(clk), .reset_i(reset_i), .data_i(data_i), .valid_i(valid_i),
        .ready_o(ready_o), .gap_i(gap_i), .clr_i(clr_i), .dout_o(dout_o),
        .shift_en_o(shift_en_o), .shift_clr_o(shift_clr_o),
        .word_done_o(word_done_o), .busy_o(busy_o), .level_o(level_o)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;

    // driver inputs
    logic [23:0] push_q[$];
    logic [3:0]  gq[$];
    int          clr_at, clr_len, rst_at;
    int          acc_q[$];

    // per-cycle log: index i = outputs seen just after edge i of the run
    logic        en_log[0:299], dout_log[0:299], wd_log[0:299];
    logic        sc_log[0:299], busy_log[0:299], rdy_log[0:299];
    logic [2:0]  lvl_log[0:299];

    // analysis results
    logic [23:0] dec_q[$];
    int          wd_q[$], rise_q[$];
    int          en_cnt, sc_cnt, first_en, last_en, part_nb;
    logic [23:0] part_acc;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [23:0] wget(input int k);
        if (k < dec_q.size()) return dec_q[k];
        return 24'hxxxxxx;
    endfunction
    function automatic int wd_at(input int k);
        if (k < wd_q.size()) return wd_q[k];
        return -1;
    endfunction
    function automatic int rise_at(input int k);
        if (k < rise_q.size()) return rise_q[k];
        return -1;
    endfunction
    function automatic int acc_at(input int k);
        if (k < acc_q.size()) return acc_q[k];
        return -1;
    endfunction

    // Drive queued words through the handshake for n cycles and log outputs.
    task automatic run(input int n);
        logic accepted;
        acc_q.delete();
        for (int i = 0; i < n; i++) begin
            clr_i   = (i >= clr_at) && (i < clr_at + clr_len);
            reset_i = (i == rst_at);
            if (push_q.size() > 0 && ready_o && !clr_i && !reset_i) begin
                data_i  = push_q[0];
                gap_i   = gq[0];
                valid_i = 1'b1;
            end else begin
                valid_i = 1'b0;
            end
            accepted = valid_i;
            tick();
            if (accepted) begin
                void'(push_q.pop_front());
                void'(gq.pop_front());
                acc_q.push_back(i);
            end
            en_log[i]   = shift_en_o;
            dout_log[i] = dout_o;
            wd_log[i]   = word_done_o;
            sc_log[i]   = shift_clr_o;
            busy_log[i] = busy_o;
            rdy_log[i]  = ready_o;
            lvl_log[i]  = level_o;
        end
        valid_i = 1'b0;
        clr_i   = 1'b0;
        reset_i = 1'b0;
    endtask

    // Receiver model: rebuild words from dout while shift_en is high.
    task automatic analyze(input int n);
        logic prev;
        dec_q.delete(); wd_q.delete(); rise_q.delete();
        en_cnt = 0; sc_cnt = 0; first_en = -1; last_en = -1;
        part_acc = 24'h0; part_nb = 0;
        for (int i = 0; i < n; i++) begin
            prev = (i == 0) ? 1'b0 : en_log[i-1];
            if (en_log[i]) begin
                en_cnt++;
                if (first_en < 0) first_en = i;
                last_en = i;
                if (!prev) rise_q.push_back(i);
                part_acc = {part_acc[22:0], dout_log[i]};
                part_nb++;
                if (part_nb == 24) begin
                    dec_q.push_back(part_acc);
                    part_nb = 0;
                end
            end
            if (wd_log[i]) wd_q.push_back(i);
            if (sc_log[i]) sc_cnt++;
        end
    endtask

    task automatic setup(input int c_at, input int c_len, input int r_at);
        clr_at = c_at; clr_len = c_len; rst_at = r_at;
    endtask

    task automatic test_reset();
        reset_i = 1'b1;
        repeat (3) tick();
        n_total++; if ({dout_o, shift_en_o, shift_clr_o, word_done_o, busy_o} !== 5'b0)
            $display("FAIL reset_outs: got %b want 00000", {dout_o, shift_en_o, shift_clr_o, word_done_o, busy_o}); else n_pass++;
        n_total++; if (level_o !== 3'd0) $display("FAIL reset_level: got %0d want 0", level_o); else n_pass++;
        n_total++; if (ready_o !== 1'b0) $display("FAIL reset_ready: got %b want 0", ready_o); else n_pass++;
        reset_i = 1'b0;
        tick();
        n_total++; if (ready_o !== 1'b1) $display("FAIL ready_after_reset: got %b want 1", ready_o); else n_pass++;
    endtask

    task automatic test_single();
        setup(1000, 0, 1000);
        push_q = '{24'h234567}; gq = '{4'd0};
        run(30); analyze(30);
        n_total++; if (acc_at(0) !== 0) $display("FAIL single_accept: got %0d want 0", acc_at(0)); else n_pass++;
        n_total++; if (lvl_log[0] !== 3'd1) $display("FAIL single_level0: got %0d want 1", lvl_log[0]); else n_pass++;
        n_total++; if (lvl_log[1] !== 3'd0) $display("FAIL single_level1: got %0d want 0", lvl_log[1]); else n_pass++;
        n_total++; if ({busy_log[0], busy_log[1]} !== 2'b01) $display("FAIL single_busy: got %b want 01", {busy_log[0], busy_log[1]}); else n_pass++;
        n_total++; if (first_en !== 2) $display("FAIL single_first_bit: got %0d want 2", first_en); else n_pass++;
        n_total++; if (en_cnt !== 24) $display("FAIL single_en_count: got %0d want 24", en_cnt); else n_pass++;
        n_total++; if (last_en !== 25) $display("FAIL single_last_bit: got %0d want 25", last_en); else n_pass++;
        n_total++; if (wget(0) !== 24'h234567) $display("FAIL single_word: got %h want 234567", wget(0)); else n_pass++;
        n_total++; if (wd_q.size() !== 1) $display("FAIL single_wd_count: got %0d want 1", wd_q.size()); else n_pass++;
        n_total++; if (wd_at(0) !== 26) $display("FAIL single_wd_pos: got %0d want 26", wd_at(0)); else n_pass++;
    endtask

    task automatic test_back_to_back();
        setup(1000, 0, 1000);
        push_q = '{24'haaaaaa, 24'h555555, 24'hffffff}; gq = '{4'd0, 4'd0, 4'd0};
        run(80); analyze(80);
        n_total++; if (acc_at(2) !== 2) $display("FAIL b2b_accept: got %0d want 2", acc_at(2)); else n_pass++;
        n_total++; if (en_cnt !== 72) $display("FAIL b2b_en_count: got %0d want 72", en_cnt); else n_pass++;
        n_total++; if (rise_q.size() !== 1) $display("FAIL b2b_contiguous: got %0d runs want 1", rise_q.size()); else n_pass++;
        n_total++; if (first_en !== 2 || last_en !== 73) $display("FAIL b2b_span: got %0d..%0d want 2..73", first_en, last_en); else n_pass++;
        n_total++; if (wd_q.size() !== 3) $display("FAIL b2b_wd_count: got %0d want 3", wd_q.size()); else n_pass++;
        n_total++; if (wd_at(0) !== 26 || wd_at(1) !== 50 || wd_at(2) !== 74)
            $display("FAIL b2b_wd_pos: got %0d,%0d,%0d want 26,50,74", wd_at(0), wd_at(1), wd_at(2)); else n_pass++;
        n_total++; if (en_log[26] !== 1'b1) $display("FAIL b2b_wd_overlap: got %b want 1", en_log[26]); else n_pass++;
        n_total++; if (wget(0) !== 24'haaaaaa || wget(1) !== 24'h555555 || wget(2) !== 24'hffffff)
            $display("FAIL b2b_words: got %h %h %h want aaaaaa 555555 ffffff", wget(0), wget(1), wget(2)); else n_pass++;
    endtask

    task automatic test_gap();
        setup(1000, 0, 1000);
        push_q = '{24'h000001, 24'hdfeabc}; gq = '{4'd3, 4'd3};
        run(60); analyze(60);
        n_total++; if (rise_at(0) !== 2 || rise_at(1) !== 29)
            $display("FAIL gap_starts: got %0d,%0d want 2,29", rise_at(0), rise_at(1)); else n_pass++;
        n_total++; if (rise_q.size() !== 2) $display("FAIL gap_frames: got %0d want 2", rise_q.size()); else n_pass++;
        n_total++; if ({en_log[25], en_log[26], en_log[27], en_log[28], en_log[29]} !== 5'b10001)
            $display("FAIL gap_idle_cycles: got %b want 10001", {en_log[25], en_log[26], en_log[27], en_log[28], en_log[29]}); else n_pass++;
        n_total++; if (wd_at(0) !== 26 || wd_at(1) !== 53)
            $display("FAIL gap_wd_pos: got %0d,%0d want 26,53", wd_at(0), wd_at(1)); else n_pass++;
        n_total++; if (wget(0) !== 24'h000001 || wget(1) !== 24'hdfeabc)
            $display("FAIL gap_words: got %h %h want 000001 dfeabc", wget(0), wget(1)); else n_pass++;
    endtask

    task automatic test_fifo_full();
        setup(1000, 0, 1000);
        push_q = '{24'h0f0f0f, 24'h123456, 24'h800001, 24'h7fffff, 24'hc3c3c3, 24'h00ff00};
        gq = '{4'd15, 4'd15, 4'd15, 4'd15, 4'd15, 4'd15};
        run(240); analyze(240);
        n_total++; if (lvl_log[4] !== 3'd4) $display("FAIL full_level: got %0d want 4", lvl_log[4]); else n_pass++;
        n_total++; if (rdy_log[3] !== 1'b1 || rdy_log[4] !== 1'b0)
            $display("FAIL full_ready_drop: got %b%b want 10", rdy_log[3], rdy_log[4]); else n_pass++;
        n_total++; if (rdy_log[39] !== 1'b0 || rdy_log[40] !== 1'b1)
            $display("FAIL full_ready_rise: got %b%b want 01", rdy_log[39], rdy_log[40]); else n_pass++;
        n_total++; if (acc_at(4) !== 4 || acc_at(5) !== 41)
            $display("FAIL full_accept: got %0d,%0d want 4,41", acc_at(4), acc_at(5)); else n_pass++;
        n_total++; if (rise_q.size() !== 6 || rise_at(5) !== 197)
            $display("FAIL full_frames: got %0d frames last at %0d want 6 at 197", rise_q.size(), rise_at(5)); else n_pass++;
        n_total++; if (wget(0) !== 24'h0f0f0f || wget(1) !== 24'h123456 || wget(2) !== 24'h800001 ||
                       wget(3) !== 24'h7fffff || wget(4) !== 24'hc3c3c3 || wget(5) !== 24'h00ff00)
            $display("FAIL full_order: got %h %h %h %h %h %h", wget(0), wget(1), wget(2), wget(3), wget(4), wget(5)); else n_pass++;
    endtask

    task automatic test_clear();
        setup(13, 1, 1000);
        push_q = '{24'h111111, 24'h222222, 24'h333333}; gq = '{4'd0, 4'd0, 4'd0};
        run(40); analyze(40);
        n_total++; if (lvl_log[12] !== 3'd2 || en_log[12] !== 1'b1)
            $display("FAIL clr_pre: got level %0d en %b want 2 1", lvl_log[12], en_log[12]); else n_pass++;
        n_total++; if ({en_log[13], dout_log[13], busy_log[13]} !== 3'b000 || lvl_log[13] !== 3'd0)
            $display("FAIL clr_state: got en/dout/busy %b%b%b level %0d want 000 0", en_log[13], dout_log[13], busy_log[13], lvl_log[13]); else n_pass++;
        n_total++; if (sc_cnt !== 1 || sc_log[13] !== 1'b1)
            $display("FAIL clr_pulse: got count %0d at13 %b want 1 1", sc_cnt, sc_log[13]); else n_pass++;
        n_total++; if (wd_q.size() !== 0) $display("FAIL clr_no_done: got %0d want 0", wd_q.size()); else n_pass++;
        n_total++; if (en_cnt !== 11 || part_acc[10:0] !== 11'b00010001000)
            $display("FAIL clr_partial: got %0d bits %b want 11 00010001000", en_cnt, part_acc[10:0]); else n_pass++;
        setup(2, 3, 1000);
        run(8); analyze(8);
        n_total++; if (sc_cnt !== 3 || sc_log[5] !== 1'b0)
            $display("FAIL clr_hold: got %0d pulses after5 %b want 3 0", sc_cnt, sc_log[5]); else n_pass++;
        setup(1000, 0, 1000);
        push_q = '{24'h5a5a5a}; gq = '{4'd0};
        run(30); analyze(30);
        n_total++; if (wget(0) !== 24'h5a5a5a || wd_at(0) !== 26)
            $display("FAIL clr_recover: got %h done at %0d want 5a5a5a 26", wget(0), wd_at(0)); else n_pass++;
    endtask

    task automatic test_reset_mid();
        setup(1000, 0, 10);
        push_q = '{24'habcdef}; gq = '{4'd0};
        run(40); analyze(40);
        n_total++; if ({en_log[10], dout_log[10], sc_log[10], wd_log[10], busy_log[10], rdy_log[10]} !== 6'b0 || lvl_log[10] !== 3'd0)
            $display("FAIL rst_mid_outs: got %b%b%b%b%b%b level %0d want 000000 0", en_log[10], dout_log[10], sc_log[10],
                     wd_log[10], busy_log[10], rdy_log[10], lvl_log[10]); else n_pass++;
        n_total++; if (rdy_log[11] !== 1'b1) $display("FAIL rst_mid_ready: got %b want 1", rdy_log[11]); else n_pass++;
        n_total++; if (wd_q.size() !== 0 || sc_cnt !== 0)
            $display("FAIL rst_mid_pulses: got done %0d clr %0d want 0 0", wd_q.size(), sc_cnt); else n_pass++;
        n_total++; if (en_cnt !== 8) $display("FAIL rst_mid_bits: got %0d want 8", en_cnt); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_gap();
        test_fifo_full();
        test_clear();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
